// File: rtl/core_clk_stepper.sv
// Clock-enable generator for a soft core: halt/run/single-step/trap-stop with a debounced step
// button and an LED probe display. Define STEP_CNT_EN to add a 32-bit issued-tick counter.
module core_clk_stepper #(
  parameter int DIV_W      = 16,
  parameter int DEB_CYCLES = 50000,
  parameter int NCH        = 4,
  parameter int CH_W       = 32,
  parameter int LED_W      = 12,
  localparam int SEL_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [1:0]          mode_i,
  input  logic [DIV_W-1:0]    div_i,
  input  logic                step_btn_i,
  input  logic                trap_i,
  input  logic [NCH*CH_W-1:0] ch_i,
  input  logic [SEL_W-1:0]    ch_sel_i,
  output logic                tick_o,
  output logic                halted_o,
  output logic                trapped_o,
  output logic [LED_W-1:0]    led_o,
  output logic [31:0]         tick_cnt_o
);

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam int LW = (LED_W < CH_W) ? LED_W : CH_W;

  localparam logic [1:0] MODE_RUN  = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP, S_TRAP} state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic [1:0]       sync_q;
  logic             stable_q, stable_d;
  logic             stable_prev_q;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [LED_W-1:0] led_q, led_d;
  logic             press;

  // Debounce: the stable level flips only after DEB_CYCLES consecutive differing samples.
  always_comb begin
    stable_d  = stable_q;
    deb_cnt_d = '0;
    if (sync_q[1] != stable_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        stable_d = sync_q[1];
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end
  end

  assign press = stable_q & ~stable_prev_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mode_i == MODE_RUN) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else if (mode_i == MODE_STEP && press) begin
          state_d = S_STEP;
          tick_d  = 1'b1;
        end
      end
      S_STEP: state_d = S_IDLE;
      S_RUN: begin
        // Trap wins over a tick due in the same cycle.
        if (trap_i) begin
          state_d = S_TRAP;
          cnt_d   = '0;
        end else if (mode_i != MODE_RUN) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= div_i) begin
          tick_d = 1'b1;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      S_TRAP: begin
        if (mode_i != MODE_RUN && mode_i != MODE_STEP) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    led_d = '0;
    for (int k = 0; k < NCH; k++) begin
      if (ch_sel_i == SEL_W'(k)) led_d[LW-1:0] = ch_i[k*CH_W +: LW];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      tick_q        <= 1'b0;
      sync_q        <= '0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      deb_cnt_q     <= '0;
      led_q         <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tick_q        <= tick_d;
      sync_q        <= {sync_q[0], step_btn_i};
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      deb_cnt_q     <= deb_cnt_d;
      led_q         <= led_d;
    end
  end

  assign tick_o    = tick_q;
  assign halted_o  = (state_q == S_IDLE) || (state_q == S_TRAP);
  assign trapped_o = (state_q == S_TRAP);
  assign led_o     = led_q;

`ifdef STEP_CNT_EN
  logic [31:0] tick_cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tick_cnt_q <= '0;
    end else if (tick_q) begin
      tick_cnt_q <= tick_cnt_q + 32'd1;
    end
  end

  assign tick_cnt_o = tick_cnt_q;
`else
  assign tick_cnt_o = '0;
`endif

  // Probe bits above the displayed width are intentionally ignored.
  logic unused_ch;
  assign unused_ch = ^ch_i;

endmodule

// File: tb/tb_core_clk_stepper.sv
// Directed bench for core_clk_stepper: run divider, debounced single-step, trap-stop, live divide
// change, LED muxing, async reset and the optional tick counter.
module tb_core_clk_stepper;
  localparam int DEB   = 8;
  localparam int NCH   = 3;
  localparam int CH_W  = 16;
  localparam int LED_W = 12;

  logic              clk = 1'b0;
  logic              resetn;
  logic [1:0]        mode_i;
  logic [15:0]       div_i;
  logic              step_btn_i;
  logic              trap_i;
  logic [NCH*CH_W-1:0] ch_i;
  logic [1:0]        ch_sel_i;
  logic              tick_o, halted_o, trapped_o;
  logic [LED_W-1:0]  led_o;
  logic [31:0]       tick_cnt_o;

  int n_vec = 0;
  int n_err = 0;

  core_clk_stepper #(
    .DIV_W(16), .DEB_CYCLES(DEB), .NCH(NCH), .CH_W(CH_W), .LED_W(LED_W)
  ) dut (
    .clk(clk), .resetn(resetn), .mode_i(mode_i), .div_i(div_i), .step_btn_i(step_btn_i),
    .trap_i(trap_i), .ch_i(ch_i), .ch_sel_i(ch_sel_i), .tick_o(tick_o), .halted_o(halted_o),
    .trapped_o(trapped_o), .led_o(led_o), .tick_cnt_o(tick_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold the button until a tick (or timeout), then release; lat=-1 if no tick seen.
  task automatic press_and_count(output int lat, output int extra);
    lat = -1;
    extra = 0;
    step_btn_i = 1'b1;
    for (int i = 1; i <= 4*DEB; i++) begin
      step(1);
      if (tick_o) begin
        if (lat < 0) lat = i;
        else extra++;
      end
    end
    step_btn_i = 1'b0;
    for (int i = 0; i < 3*DEB; i++) begin
      step(1);
      if (tick_o) extra++;
    end
  endtask

  initial begin
    int lat, extra, n, found, extras;
    resetn = 1'b0; mode_i = 2'b00; div_i = '0; step_btn_i = 1'b0; trap_i = 1'b0;
    ch_i = '0; ch_sel_i = '0;
    step(2);
    chk("rst_tick", 32'(tick_o), 0);
    chk("rst_halted", 32'(halted_o), 1);
    chk("rst_trapped", 32'(trapped_o), 0);
    chk("rst_led", 32'(led_o), 0);
    chk("rst_tick_cnt", tick_cnt_o, 0);
    resetn = 1'b1;

    // RUN with div 3: ticks on cycles 4, 8, 12 only
    div_i = 16'd3; mode_i = 2'b01;
    step(1);
    chk("run_halted", 32'(halted_o), 0);
    for (int c = 1; c <= 12; c++) begin
      step(1);
      chk($sformatf("run_div3_c%0d", c), 32'(tick_o), (c % 4 == 0) ? 32'd1 : 32'd0);
    end
    mode_i = 2'b00;
    step(1);
    chk("halt_tick", 32'(tick_o), 0);
    chk("halt_halted", 32'(halted_o), 1);

    // LED display
    ch_i = {16'hFABC, 16'h0123, 16'h0456}; ch_sel_i = 2'd2;
    chk("led_latency", 32'(led_o), 0);
    step(1);
    chk("led_sel2", 32'(led_o), 32'hABC);
    ch_sel_i = 2'd0; step(1);
    chk("led_sel0", 32'(led_o), 32'h456);
    ch_sel_i = 2'd3; step(1);
    chk("led_sel_oor", 32'(led_o), 0);
    ch_sel_i = 2'd1; step(1);
    chk("led_sel1", 32'(led_o), 32'h123);

    // Bouncing button in STEP mode, then held
    mode_i = 2'b10;
    step_btn_i = 1'b1; step(1);
    step_btn_i = 1'b0; step(1);
    step_btn_i = 1'b1; step(1);
    step_btn_i = 1'b0; step(1);
    press_and_count(lat, extra);
    chk("bounce_latency", 32'(lat), 32'(DEB + 3));
    chk("bounce_one_tick", 32'(extra), 0);
    press_and_count(lat, extra);
    chk("repress_latency", 32'(lat), 32'(DEB + 3));
    chk("repress_one_tick", 32'(extra), 0);

    // Trap stops ticks and blocks steps until HALT
    mode_i = 2'b01; div_i = 16'd0;
    step(3);
    chk("trap_pre_tick", 32'(tick_o), 1);
    trap_i = 1'b1; step(1);
    chk("trap_tick", 32'(tick_o), 0);
    chk("trap_trapped", 32'(trapped_o), 1);
    chk("trap_halted", 32'(halted_o), 1);
    trap_i = 1'b0; step(1);
    chk("trap_still", 32'(tick_o), 0);
    mode_i = 2'b10;
    press_and_count(lat, extra);
    chk("trap_step_none", 32'(lat), 32'hFFFF_FFFF);
    chk("trap_step_extra", 32'(extra), 0);
    chk("trap_held", 32'(trapped_o), 1);
    mode_i = 2'b00; step(1);
    chk("untrap_trapped", 32'(trapped_o), 0);
    chk("untrap_halted", 32'(halted_o), 1);

    // Live divide shrink below current count
    mode_i = 2'b01; div_i = 16'd100;
    step(51);
    chk("div100_no_tick", 32'(tick_o), 0);
    div_i = 16'd10; step(1);
    chk("shrink_tick", 32'(tick_o), 1);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      n++;
      if (tick_o) break;
    end
    chk("shrink_period", 32'(n), 11);

    // Reserved mode acts as HALT
    div_i = 16'd0; step(2);
    chk("pre_rsvd_tick", 32'(tick_o), 1);
    mode_i = 2'b11; step(1);
    chk("rsvd_tick", 32'(tick_o), 0);
    chk("rsvd_halted", 32'(halted_o), 1);
    step(3);
    chk("rsvd_stay_halted", 32'(halted_o), 1);

    // Async reset in the middle of RUN
    mode_i = 2'b01; step(3);
    chk("prerst_tick", 32'(tick_o), 1);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_tick", 32'(tick_o), 0);
    chk("async_rst_halted", 32'(halted_o), 1);
    chk("async_rst_cnt", tick_cnt_o, 0);
    mode_i = 2'b00;
    step(1);
    resetn = 1'b1;

    // 7 steps + 20 RUN ticks for the tick counter
    mode_i = 2'b10;
    found = 0; extras = 0;
    for (int s = 0; s < 7; s++) begin
      press_and_count(lat, extra);
      if (lat == DEB + 3) found++;
      extras += extra;
    end
    chk("seven_steps", 32'(found), 7);
    chk("seven_steps_extra", 32'(extras), 0);
    mode_i = 2'b01; div_i = 16'd0;
    step(21);
    mode_i = 2'b00;
    step(4);
`ifdef STEP_CNT_EN
    chk("tick_cnt", tick_cnt_o, 32'd27);
`else
    chk("tick_cnt", tick_cnt_o, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
